// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the RV32E core.
// Hazard sequencer states and pipeline constants.
package pipeline_pkg;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      MEM_WAIT   = 2'd1,
      FETCH_WAIT = 2'd2,
      HALTED     = 2'd3
   } hcu_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam int          REG_IDX_W = 4;

endpackage

// File: rtl/hazard_event_counter.sv
// Wrap-around event counter for pipeline performance debug.
// Counts cycles with en high; rolls over silently.
module hazard_event_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   // Increment on each enabled cycle, modulo 2^CNT_W
   always_ff @(posedge clk or posedge rst) begin
      if (rst) count <= '0;
      else if (en) count <= count + 1'b1;
   end

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush sequencer for the 5-stage RV32E pipeline.
// Handles load-use, redirects, memory waits and halt.
module hazard_control_unit
   import pipeline_pkg::*;
#(
   parameter int          NUM_REGS = 16,
   parameter int          CNT_W    = 16,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [$clog2(NUM_REGS)-1:0] rs1_ID,
   input  logic [$clog2(NUM_REGS)-1:0] rs2_ID,
   input  logic                        uses_rs1_ID,
   input  logic                        uses_rs2_ID,
   input  logic [$clog2(NUM_REGS)-1:0] rd_EX,
   input  logic                        mem_read_EX,
   input  logic                        branch_taken_EX,
   input  logic [31:0]                 branch_target_EX,
   input  logic                        dmem_req_MEM,
   input  logic                        dmem_ready_MEM,
   input  logic                        imem_ready_IF,
   input  logic                        halt_req,
   output logic                        stall_PC,
   output logic                        stall_IF_ID,
   output logic                        invalid_IF,
   output logic                        bubble_ID_EX,
   output logic                        stall_EX_MEM,
   output logic                        redirect_valid,
   output logic [31:0]                 redirect_pc,
   output logic [1:0]                  state,
   output logic [CNT_W-1:0]            cnt_load_use,
   output logic [CNT_W-1:0]            cnt_flush,
   output logic [CNT_W-1:0]            cnt_mem_wait
);

   hcu_state_t  cur, nxt;
   logic        pend_valid;
   logic [31:0] pend_pc;
   logic [31:0] last_pc;
   logic        load_use, mem_busy;
   logic        freeze, capture;
   logic        inc_lu, inc_fl, inc_mw;

   assign load_use = mem_read_EX && (rd_EX != '0) &&
                     ((uses_rs1_ID && rs1_ID == rd_EX) ||
                      (uses_rs2_ID && rs2_ID == rd_EX));
   assign mem_busy = dmem_req_MEM && !dmem_ready_MEM;
   assign state    = cur;

   // State register; rst aborts any state at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cur <= RUN;
      else cur <= nxt;
   end

   // Pending redirect and last issued target
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_valid <= 1'b0;
         pend_pc    <= RESET_PC;
         last_pc    <= RESET_PC;
      end else begin
         if (redirect_valid) begin
            pend_valid <= 1'b0;
            last_pc    <= redirect_pc;
         end else if (capture && !pend_valid) begin
            pend_valid <= 1'b1;
            pend_pc    <= branch_target_EX;
         end
      end
   end

   // Next state and control outputs in priority order
   always_comb begin
      nxt            = cur;
      freeze         = 1'b0;
      capture        = 1'b0;
      inc_lu         = 1'b0;
      inc_fl         = 1'b0;
      inc_mw         = 1'b0;
      stall_PC       = 1'b0;
      stall_IF_ID    = 1'b0;
      invalid_IF     = 1'b0;
      bubble_ID_EX   = 1'b0;
      redirect_valid = 1'b0;
      unique case (cur)
         HALTED: begin
            if (halt_req) freeze = 1'b1;
            else nxt = RUN;
         end
         MEM_WAIT: begin
            capture = branch_taken_EX;
            if (mem_busy) begin
               freeze = 1'b1;
               inc_mw = 1'b1;
            end else begin
               nxt = RUN;
            end
         end
         default: begin
            nxt = RUN;
            if (mem_busy) begin
               freeze  = 1'b1;
               inc_mw  = 1'b1;
               capture = branch_taken_EX;
               nxt     = MEM_WAIT;
            end else if (halt_req) begin
               freeze = 1'b1;
               nxt    = HALTED;
            end else if (branch_taken_EX || pend_valid) begin
               redirect_valid = 1'b1;
               invalid_IF     = 1'b1;
               bubble_ID_EX   = 1'b1;
               inc_fl         = 1'b1;
            end else if (!imem_ready_IF) begin
               stall_PC   = 1'b1;
               invalid_IF = 1'b1;
               nxt        = FETCH_WAIT;
            end else if (load_use) begin
               stall_PC     = 1'b1;
               stall_IF_ID  = 1'b1;
               bubble_ID_EX = 1'b1;
               inc_lu       = 1'b1;
            end
         end
      endcase
      if (freeze) begin
         stall_PC    = 1'b1;
         stall_IF_ID = 1'b1;
      end
      stall_EX_MEM = freeze;
      if (rst) begin
         nxt            = RUN;
         capture        = 1'b0;
         inc_lu         = 1'b0;
         inc_fl         = 1'b0;
         inc_mw         = 1'b0;
         stall_PC       = 1'b0;
         stall_IF_ID    = 1'b0;
         invalid_IF     = 1'b1;
         bubble_ID_EX   = 1'b0;
         stall_EX_MEM   = 1'b0;
         redirect_valid = 1'b0;
      end
      if (redirect_valid) begin
         redirect_pc = pend_valid ? pend_pc : branch_target_EX;
      end else begin
         redirect_pc = last_pc;
      end
   end

   hazard_event_counter #(.CNT_W(CNT_W)) u_cnt_lu (
      .clk   (clk),
      .rst   (rst),
      .en    (inc_lu),
      .count (cnt_load_use)
   );

   hazard_event_counter #(.CNT_W(CNT_W)) u_cnt_fl (
      .clk   (clk),
      .rst   (rst),
      .en    (inc_fl),
      .count (cnt_flush)
   );

   hazard_event_counter #(.CNT_W(CNT_W)) u_cnt_mw (
      .clk   (clk),
      .rst   (rst),
      .en    (inc_mw),
      .count (cnt_mem_wait)
   );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Randomized self-checking bench for hazard_control_unit.
// Reference model works from event priorities per cycle.
module tb_hazard_control_unit;

   localparam int          CNT_W = 4;
   localparam int          MODV  = 1 << CNT_W;
   localparam logic [31:0] RPC   = 32'h0000_1000;

   logic             clk;
   logic             rst;
   logic [3:0]       rs1_ID, rs2_ID, rd_EX;
   logic             uses_rs1_ID, uses_rs2_ID;
   logic             mem_read_EX, branch_taken_EX;
   logic [31:0]      branch_target_EX;
   logic             dmem_req_MEM, dmem_ready_MEM;
   logic             imem_ready_IF, halt_req;
   logic             stall_PC, stall_IF_ID, invalid_IF;
   logic             bubble_ID_EX, stall_EX_MEM;
   logic             redirect_valid;
   logic [31:0]      redirect_pc;
   logic [1:0]       state;
   logic [CNT_W-1:0] cnt_load_use, cnt_flush, cnt_mem_wait;

   hazard_control_unit #(
      .NUM_REGS (16),
      .CNT_W    (CNT_W),
      .RESET_PC (RPC)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .rs1_ID           (rs1_ID),
      .rs2_ID           (rs2_ID),
      .uses_rs1_ID      (uses_rs1_ID),
      .uses_rs2_ID      (uses_rs2_ID),
      .rd_EX            (rd_EX),
      .mem_read_EX      (mem_read_EX),
      .branch_taken_EX  (branch_taken_EX),
      .branch_target_EX (branch_target_EX),
      .dmem_req_MEM     (dmem_req_MEM),
      .dmem_ready_MEM   (dmem_ready_MEM),
      .imem_ready_IF    (imem_ready_IF),
      .halt_req         (halt_req),
      .stall_PC         (stall_PC),
      .stall_IF_ID      (stall_IF_ID),
      .invalid_IF       (invalid_IF),
      .bubble_ID_EX     (bubble_ID_EX),
      .stall_EX_MEM     (stall_EX_MEM),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .state            (state),
      .cnt_load_use     (cnt_load_use),
      .cnt_flush        (cnt_flush),
      .cnt_mem_wait     (cnt_mem_wait)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Model: mode 0=run 1=mem wait 2=fetch wait 3=halted
   typedef enum {A_IDLE, A_FREEZE, A_FLUSH, A_FETCH, A_LU} act_t;

   int          m_mode, n_mode;
   bit          m_pv, n_pv;
   logic [31:0] m_pt, n_pt, m_last, n_last;
   int          m_lu, n_lu, m_fl, n_fl, m_mw, n_mw;
   logic [5:0]  e_ctl;
   logic [31:0] e_pc;

   task automatic model_reset();
      m_mode = 0;
      m_pv   = 0;
      m_pt   = RPC;
      m_last = RPC;
      m_lu   = 0;
      m_fl   = 0;
      m_mw   = 0;
   endtask

   task automatic model_eval();
      bit   lu, busy;
      act_t act;
      logic [31:0] t;
      lu = mem_read_EX && rd_EX != 0 &&
           ((uses_rs1_ID && rs1_ID == rd_EX) ||
            (uses_rs2_ID && rs2_ID == rd_EX));
      busy   = dmem_req_MEM && !dmem_ready_MEM;
      act    = A_IDLE;
      t      = m_last;
      n_mode = 0;
      n_pv   = m_pv;
      n_pt   = m_pt;
      n_last = m_last;
      n_lu   = m_lu;
      n_fl   = m_fl;
      n_mw   = m_mw;
      if (m_mode == 3) begin
         if (halt_req) begin
            act    = A_FREEZE;
            n_mode = 3;
         end
      end else if (m_mode == 1) begin
         if (busy) begin
            act    = A_FREEZE;
            n_mode = 1;
            n_mw   = (m_mw + 1) % MODV;
         end
         if (branch_taken_EX && !m_pv) begin
            n_pv = 1;
            n_pt = branch_target_EX;
         end
      end else if (busy) begin
         act    = A_FREEZE;
         n_mode = 1;
         n_mw   = (m_mw + 1) % MODV;
         if (branch_taken_EX && !m_pv) begin
            n_pv = 1;
            n_pt = branch_target_EX;
         end
      end else if (halt_req) begin
         act    = A_FREEZE;
         n_mode = 3;
      end else if (branch_taken_EX || m_pv) begin
         act    = A_FLUSH;
         t      = m_pv ? m_pt : branch_target_EX;
         n_last = t;
         n_pv   = 0;
         n_fl   = (m_fl + 1) % MODV;
      end else if (!imem_ready_IF) begin
         act    = A_FETCH;
         n_mode = 2;
      end else if (lu) begin
         act  = A_LU;
         n_lu = (m_lu + 1) % MODV;
      end
      // {stall_PC, stall_IF_ID, invalid_IF, bubble, stall_EX_MEM, redirect}
      case (act)
         A_FREEZE: e_ctl = 6'b110010;
         A_FLUSH:  e_ctl = 6'b001101;
         A_FETCH:  e_ctl = 6'b101000;
         A_LU:     e_ctl = 6'b110100;
         default:  e_ctl = 6'b000000;
      endcase
      e_pc = t;
   endtask

   task automatic model_commit();
      m_mode = n_mode;
      m_pv   = n_pv;
      m_pt   = n_pt;
      m_last = n_last;
      m_lu   = n_lu;
      m_fl   = n_fl;
      m_mw   = n_mw;
   endtask

   function automatic logic [31:0] ctl();
      return 32'({stall_PC, stall_IF_ID, invalid_IF,
                  bubble_ID_EX, stall_EX_MEM, redirect_valid});
   endfunction

   // Called at negedge with inputs already driven
   task automatic step();
      #1;
      model_eval();
      check("ctl", ctl(), 32'(e_ctl));
      check("rpc", redirect_pc, e_pc);
      check("state", 32'(state), 32'(m_mode));
      check("cnt_lu", 32'(cnt_load_use), 32'(m_lu));
      check("cnt_fl", 32'(cnt_flush), 32'(m_fl));
      check("cnt_mw", 32'(cnt_mem_wait), 32'(m_mw));
      @(posedge clk);
      model_commit();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst_ctl", ctl(), 32'h0000_0008);
      check("rst_state", 32'(state), 32'd0);
      check("rst_rpc", redirect_pc, RPC);
      check("rst_cnt_lu", 32'(cnt_load_use), 32'd0);
      check("rst_cnt_fl", 32'(cnt_flush), 32'd0);
      check("rst_cnt_mw", 32'(cnt_mem_wait), 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic idle();
      rs1_ID           = 4'd0;
      rs2_ID           = 4'd0;
      rd_EX            = 4'd0;
      uses_rs1_ID      = 1'b0;
      uses_rs2_ID      = 1'b0;
      mem_read_EX      = 1'b0;
      branch_taken_EX  = 1'b0;
      branch_target_EX = 32'h0;
      dmem_req_MEM     = 1'b0;
      dmem_ready_MEM   = 1'b0;
      imem_ready_IF    = 1'b1;
      halt_req         = 1'b0;
   endtask

   task automatic set_lu(input logic [3:0] rd);
      mem_read_EX = 1'b1;
      rd_EX       = rd;
      rs1_ID      = 4'd5;
      uses_rs1_ID = 1'b1;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      @(negedge clk);
      do_reset();

      // Load-use, then the same pattern on x0
      set_lu(4'd5);
      #1;
      check("lu_ctl", ctl(), 32'h0000_0034);
      step();
      check("lu_cnt", 32'(cnt_load_use), 32'd1);
      idle();
      step();
      set_lu(4'd0);
      #1;
      check("lu_x0_ctl", ctl(), 32'd0);
      step();
      check("lu_x0_cnt", 32'(cnt_load_use), 32'd1);

      // Taken branch redirect
      idle();
      branch_taken_EX  = 1'b1;
      branch_target_EX = 32'h0000_0120;
      #1;
      check("br_ctl", ctl(), 32'h0000_000D);
      check("br_pc", redirect_pc, 32'h0000_0120);
      step();
      check("br_cnt", 32'(cnt_flush), 32'd1);
      idle();
      step();

      // Memory wait with a coincident branch
      do_reset();
      dmem_req_MEM     = 1'b1;
      branch_taken_EX  = 1'b1;
      branch_target_EX = 32'h0000_0200;
      step();
      check("mw_state", 32'(state), 32'd1);
      branch_taken_EX = 1'b0;
      step();
      step();
      check("mw_cnt", 32'(cnt_mem_wait), 32'd3);
      dmem_ready_MEM = 1'b1;
      step();
      check("mw_exit", 32'(state), 32'd0);
      idle();
      #1;
      check("mw_redir", 32'(redirect_valid), 32'd1);
      check("mw_pc", redirect_pc, 32'h0000_0200);
      step();

      // Fetch wait
      imem_ready_IF = 1'b0;
      step();
      check("fw_state", 32'(state), 32'd2);
      step();
      imem_ready_IF = 1'b1;
      #1;
      check("fw_rel", ctl(), 32'd0);
      step();
      check("fw_run", 32'(state), 32'd0);

      // Halt, then reset while halted
      halt_req = 1'b1;
      step();
      check("halt_state", 32'(state), 32'd3);
      step();
      do_reset();
      idle();
      step();

      // Counter wrap at 2^CNT_W
      do_reset();
      set_lu(4'd5);
      repeat (MODV - 1) step();
      check("wrap_pre", 32'(cnt_load_use), 32'(MODV - 1));
      step();
      check("wrap_zero", 32'(cnt_load_use), 32'd0);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
         end else begin
            rs1_ID           = 4'($urandom_range(0, 3));
            rs2_ID           = 4'($urandom_range(0, 3));
            rd_EX            = 4'($urandom_range(0, 3));
            uses_rs1_ID      = 1'($urandom_range(0, 1));
            uses_rs2_ID      = 1'($urandom_range(0, 1));
            mem_read_EX      = ($urandom_range(0, 99) < 40);
            branch_taken_EX  = ($urandom_range(0, 99) < 15);
            branch_target_EX = $urandom & 32'hFFFF_FFFC;
            dmem_req_MEM     = ($urandom_range(0, 99) < 25);
            dmem_ready_MEM   = ($urandom_range(0, 99) < 50);
            imem_ready_IF    = ($urandom_range(0, 99) < 80);
            halt_req         = ($urandom_range(0, 99) < 8);
            step();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
Central stall/flush sequencer for the 5-stage RV32E pipeline.
- Drives the stall and invalid controls of the IF/ID register and the hold/bubble controls of the ID/EX, EX/MEM and PC stages.
- Resolves load-use hazards, taken-branch redirects, instruction/data memory wait states and halt requests.
- Keeps wrap-around event counters for performance debug.

Parameters:
NUM_REGS, 16, architectural register count (RV32E); source/destination fields are $clog2(NUM_REGS) bits.
CNT_W, 16, width of each event counter.
RESET_PC, 32'h0000_0000, initial redirect_pc value.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  asynchronous, active-high reset.
rs1_ID  in  4  rs1 field of the instruction in ID.
rs2_ID  in  4  rs2 field of the instruction in ID.
uses_rs1_ID  in  1  ID instruction reads rs1.
uses_rs2_ID  in  1  ID instruction reads rs2.
rd_EX  in  4  destination register of the instruction in EX.
mem_read_EX  in  1  EX instruction is a load.
branch_taken_EX  in  1  EX resolved a taken branch or jump.
branch_target_EX  in  32  target PC for the taken branch.
dmem_req_MEM  in  1  MEM stage has an active data access.
dmem_ready_MEM  in  1  data memory completes the access this cycle.
imem_ready_IF  in  1  instruction memory returns valid data this cycle.
halt_req  in  1  level request to freeze the pipeline (debug).
stall_PC  out  1  hold the PC register.
stall_IF_ID  out  1  hold the IF/ID payload (drives IF/ID stall).
invalid_IF  out  1  mark the IF/ID entry invalid, so it becomes a NOP (0x13).
bubble_ID_EX  out  1  load a NOP into ID/EX.
stall_EX_MEM  out  1  hold EX/MEM and all upstream registers.
redirect_valid  out  1  PC must load redirect_pc next edge.
redirect_pc  out  32  redirect target.
state  out  2  FSM state encoding.
cnt_load_use  out  CNT_W  load-use stall cycles.
cnt_flush  out  CNT_W  redirects issued.
cnt_mem_wait  out  CNT_W  data-memory wait cycles.

Behaviour:
FSM states: RUN=0, MEM_WAIT=1, FETCH_WAIT=2, HALTED=3.

Reset:
- state=RUN.
- All counters = 0.
- redirect_pc = RESET_PC, redirect_valid = 0.
- Pending-redirect register cleared.
- All stall/bubble outputs = 0, except invalid_IF=1 while rst is asserted.
- An rst assertion mid-operation aborts any state immediately, including a pending redirect.

Hazard definitions:
- load_use = mem_read_EX && rd_EX!=0 && ((uses_rs1_ID && rs1_ID==rd_EX) || (uses_rs2_ID && rs2_ID==rd_EX)).
- x0 never creates a hazard.
- mem_busy = dmem_req_MEM && !dmem_ready_MEM.

Priority when events coincide (highest first): rst > mem_busy > halt_req > branch_taken_EX > !imem_ready_IF > load_use.

RUN:
- mem_busy: assert stall_PC, stall_IF_ID, stall_EX_MEM, bubble_ID_EX=0. Go to MEM_WAIT; cnt_mem_wait+1. A coincident branch_taken_EX is captured into the pending register (valid + target); no redirect yet.
- halt_req: assert all holds. Go to HALTED.
- branch_taken_EX: redirect_valid=1, redirect_pc=branch_target_EX, invalid_IF=1, bubble_ID_EX=1, stall_PC=0. Same-cycle combinational outputs, one cycle wide. cnt_flush+1. A load_use in the same cycle is ignored, because the ID instruction is squashed.
- !imem_ready_IF: stall_PC=1, invalid_IF=1. Go to FETCH_WAIT.
- load_use: stall_PC=1, stall_IF_ID=1, bubble_ID_EX=1 for exactly one cycle. cnt_load_use+1. Stay in RUN.

MEM_WAIT:
- Holds asserted every cycle while mem_busy; cnt_mem_wait+1 per cycle.
- A branch arriving while no redirect is pending is captured into the pending register.
- Exit to RUN on the cycle dmem_ready_MEM=1, with holds released that cycle.
- On the first RUN cycle, a valid pending redirect is issued exactly like a fresh branch, then cleared.

FETCH_WAIT:
- invalid_IF=1 and stall_PC=1 until imem_ready_IF=1, then go to RUN.
- A branch or mem_busy here follows the RUN rules with the same priority.

HALTED:
- Holds stay asserted while halt_req=1.
- On deassertion, go to RUN with no side effects.

Counters: wrap modulo 2^CNT_W; no saturation.

Decomposition:
- Shared package pipeline_pkg: hcu_state_t enum (RUN/MEM_WAIT/FETCH_WAIT/HALTED), NOP_INSTR=32'h13, REG_IDX_W=4.
- One sub-module, hazard_event_counter: CNT_W wrap counter with async reset and an increment enable, instantiated three times.

Test Plan:
1. Load-use: mem_read_EX=1, rd_EX=5, rs1_ID=5, uses_rs1_ID=1 for one cycle -> stall_PC=stall_IF_ID=bubble_ID_EX=1 for 1 cycle; cnt_load_use=1. Same stimulus with rd_EX=0 -> no stall.
2. Branch: branch_taken_EX=1, target 0x0000_0120 -> redirect_valid=1, redirect_pc=0x120, invalid_IF=1, bubble_ID_EX=1 for one cycle; cnt_flush=1.
3. Memory wait with coincident branch: dmem_req_MEM=1, dmem_ready_MEM=0 for 3 cycles, branch_taken_EX=1 (target 0x200) on cycle 1 -> state=MEM_WAIT, holds for 3 cycles, cnt_mem_wait=3; ready on cycle 4 -> the next cycle shows redirect_valid=1, redirect_pc=0x200.
4. Fetch wait: imem_ready_IF=0 for 2 cycles -> state=FETCH_WAIT, invalid_IF=stall_PC=1; release -> RUN with outputs cleared.
5. Halt plus reset: halt_req=1 -> HALTED with all holds; assert rst mid-HALTED -> immediately RUN, counters 0, redirect_pc=RESET_PC.
6. Counter wrap: CNT_W=4, 16 load-use events -> cnt_load_use returns to 0.
